rfe_sweep_ctrl: RTL and testbench



---
 rtl/rfe_sweep_pkg.sv | 24 ++
 rtl/rfe_sweep_ctrl_if.sv | 9 +
 rtl/rfe_sweep_table.sv | 58 +++++
 rtl/rfe_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rfe_sweep_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rfe_sweep_pkg.sv
// Shared types and constants for the RFE switch/filter sweep sequencer.
package rfe_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_DWELL   = 2'd2,
    ST_ADVANCE = 2'd3
  } sweep_state_e;

  // Register offsets from BASE_ADDR
  localparam logic [6:0] REG_CTRL   = 7'd0;
  localparam logic [6:0] REG_TABLE  = 7'd1;
  localparam logic [6:0] REG_SETTLE = 7'd2;

  // CTRL register bit positions
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CONT     = 1;
  localparam int unsigned CTRL_ABORT    = 2;
  localparam int unsigned CTRL_LAST_LSB = 8;

  localparam int unsigned DWELL_W = 16;

endpackage

// File: rtl/rfe_sweep_ctrl_if.sv
// Serial register write bus (serial_strobe/serial_addr/serial_data) in the adcclk domain.
interface rfe_sweep_ctrl_if;
  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;

  modport master (output serial_strobe, output serial_addr, output serial_data);
  modport slave  (input  serial_strobe, input  serial_addr, input  serial_data);
endinterface

// File: rtl/rfe_sweep_table.sv
// Sweep table: NUM_ENTRIES x {switch word, dwell} with one write port and an async read port.
module rfe_sweep_table #(
  parameter int unsigned SW_WIDTH    = 6,
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned IDX_W       = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [3:0]          wr_idx,
  input  logic [SW_WIDTH-1:0] wr_sw,
  input  logic [15:0]         wr_dwell,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [SW_WIDTH-1:0] rd_sw,
  output logic [15:0]         rd_dwell
);

  logic [SW_WIDTH-1:0] sw_q    [NUM_ENTRIES];
  logic [SW_WIDTH-1:0] sw_d    [NUM_ENTRIES];
  logic [15:0]         dwell_q [NUM_ENTRIES];
  logic [15:0]         dwell_d [NUM_ENTRIES];

  // Indices at or beyond NUM_ENTRIES match no entry, so such writes drop and reads return zero.
  always_comb begin
    sw_d    = sw_q;
    dwell_d = dwell_q;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (wr_en && (wr_idx == 4'(i))) begin
        sw_d[i]    = wr_sw;
        dwell_d[i] = wr_dwell;
      end
    end
  end

  always_comb begin
    rd_sw    = '0;
    rd_dwell = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_sw    = sw_q[i];
        rd_dwell = dwell_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        sw_q[i]    <= '0;
        dwell_q[i] <= '0;
      end
    end else begin
      sw_q    <= sw_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/rfe_sweep_ctrl.sv
// Table-driven RFE switch/filter sweep sequencer (IDLE/SETTLE/DWELL/ADVANCE).
// Optional `RFE_SWEEP_HOLD_EN adds a hold input that freezes the dwell counter.
module rfe_sweep_ctrl
  import rfe_sweep_pkg::*;
#(
  parameter logic [6:0]  BASE_ADDR   = 7'd80,
  parameter int unsigned SW_WIDTH    = 6,
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned IDX_W       = 4
) (
  input  logic                clock,
  input  logic                reset,
  rfe_sweep_ctrl_if.slave     sbus,
`ifdef RFE_SWEEP_HOLD_EN
  input  logic                hold,
`endif
  output logic [SW_WIDTH-1:0] sw_out,
  output logic                capture_en,
  output logic [IDX_W-1:0]    cur_idx,
  output logic                busy,
  output logic                sweep_done
);

  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_ENTRIES - 1);

  sweep_state_e        state_q, state_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  settle_q, settle_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [SW_WIDTH-1:0] sw_q, sw_d;
  logic                cont_q, cont_d;

  logic                wr_ctrl, wr_table, wr_settle;
  logic                start_req, abort_req, last_hit, dwell_hold;
  logic [IDX_W-1:0]    last_field, rd_idx;
  logic [SW_WIDTH-1:0] rd_sw;
  logic [DWELL_W-1:0]  rd_dwell;
  logic [11:0]         sw_field;
  logic                unused_sw_field;

  assign wr_ctrl   = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + REG_CTRL);
  assign wr_table  = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + REG_TABLE);
  assign wr_settle = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + REG_SETTLE);
  assign start_req = wr_ctrl && sbus.serial_data[CTRL_START];
  assign abort_req = wr_ctrl && sbus.serial_data[CTRL_ABORT];

  assign last_field      = sbus.serial_data[CTRL_LAST_LSB +: IDX_W];
  assign sw_field        = sbus.serial_data[27:16];
  assign unused_sw_field = ^sw_field;

`ifdef RFE_SWEEP_HOLD_EN
  assign dwell_hold = hold;
`else
  assign dwell_hold = 1'b0;
`endif

  // >= rather than == so a live lowering of last below cur_idx still ends the pass.
  assign last_hit = (idx_q >= last_q);

  // Single read port: the entry about to be latched, or entry 0 for the live IDLE view.
  always_comb begin
    rd_idx = '0;
    unique case (state_q)
      ST_SETTLE:  rd_idx = idx_q;
      ST_ADVANCE: rd_idx = last_hit ? '0 : idx_q + 1'b1;
      default:    rd_idx = '0;
    endcase
  end

  rfe_sweep_table #(
    .SW_WIDTH    (SW_WIDTH),
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_table),
    .wr_idx   (sbus.serial_data[31:28]),
    .wr_sw    (sw_field[SW_WIDTH-1:0]),
    .wr_dwell (sbus.serial_data[15:0]),
    .rd_idx   (rd_idx),
    .rd_sw    (rd_sw),
    .rd_dwell (rd_dwell)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    last_d   = last_q;
    sw_d     = sw_q;
    cont_d   = cont_q;

    if (wr_settle) settle_d = sbus.serial_data[15:0];
    if (wr_ctrl) begin
      cont_d = sbus.serial_data[CTRL_CONT];
      last_d = (last_field > LAST_MAX) ? LAST_MAX : last_field;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
          cnt_d   = settle_q;
          sw_d    = rd_sw;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_DWELL;
          cnt_d   = rd_dwell;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      ST_DWELL: begin
        if (!dwell_hold) begin
          if (cnt_q == '0) state_d = ST_ADVANCE;
          else             cnt_d   = cnt_q - DWELL_W'(1);
        end
      end
      ST_ADVANCE: begin
        state_d = ST_SETTLE;
        cnt_d   = settle_q;
        sw_d    = rd_sw;
        if (last_hit) begin
          idx_d = '0;
          if (!cont_q) state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase

    if (abort_req) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      sw_q     <= '0;
      cont_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      sw_q     <= sw_d;
      cont_q   <= cont_d;
    end
  end

  assign sw_out     = (state_q == ST_IDLE) ? rd_sw : sw_q;
  assign capture_en = (state_q == ST_DWELL);
  assign cur_idx    = idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign sweep_done = (state_q == ST_ADVANCE) && last_hit && !abort_req;

endmodule

// File: tb/tb_rfe_sweep_ctrl.sv
// Scoreboard bench for rfe_sweep_ctrl: expected dwell/done events queued from a sweep model.
module tb_rfe_sweep_ctrl;

  localparam logic [6:0] BASE = 7'd80;
  localparam int NE = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] sw_out;
  logic       capture_en;
  logic [3:0] cur_idx;
  logic       busy;
  logic       sweep_done;
`ifdef RFE_SWEEP_HOLD_EN
  logic       hold = 1'b0;
`endif

  rfe_sweep_ctrl_if sbus ();

  rfe_sweep_ctrl #(
    .BASE_ADDR   (BASE),
    .SW_WIDTH    (6),
    .NUM_ENTRIES (8),
    .IDX_W       (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sbus       (sbus),
`ifdef RFE_SWEEP_HOLD_EN
    .hold       (hold),
`endif
    .sw_out     (sw_out),
    .capture_en (capture_en),
    .cur_idx    (cur_idx),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clock = ~clock;

  typedef enum int {EV_START, EV_END, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       a;   // START: switch word, END: capture cycles, DONE: index
    int       b;   // START: index
    int       c;   // START: busy non-capture cycles before capture
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference model of the programmed registers
  int m_sw[NE];
  int m_dw[NE];
  int m_settle;
  int m_last;

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic bit pop_ev(input ev_kind_e k, output ev_t e);
    n_tests++;
    e = '{EV_START, 0, 0, 0};
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s, expected none", k.name());
      return 1'b0;
    end
    e = exp_q.pop_front();
    if (e.kind != k) begin
      n_fail++;
      $display("FAIL event_order: got %s, expected %s", k.name(), e.kind.name());
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor: turns DUT outputs into events and scores them against the queue.
  bit cap_prev = 1'b0;
  int pre_cnt  = 0;
  int cap_len  = 0;
  always @(negedge clock) begin
    ev_t e;
    if (reset) begin
      cap_prev = 1'b0;
      pre_cnt  = 0;
      cap_len  = 0;
    end else begin
      if (capture_en) begin
        if (!cap_prev) begin
          if (pop_ev(EV_START, e)) begin
            check("start_sw", int'(sw_out), e.a);
            check("start_idx", int'(cur_idx), e.b);
            check("settle_cycles", pre_cnt, e.c);
          end
          cap_len = 0;
        end
        cap_len++;
        pre_cnt = 0;
      end else begin
        if (cap_prev && pop_ev(EV_END, e)) check("dwell_cycles", cap_len, e.a);
        pre_cnt = busy ? pre_cnt + 1 : 0;
      end
      if (sweep_done && pop_ev(EV_DONE, e)) check("done_idx", int'(cur_idx), e.a);
      cap_prev = capture_en;
    end
  end

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    sbus.serial_strobe = 1'b1;
    sbus.serial_addr   = a;
    sbus.serial_data   = d;
    @(negedge clock);
    sbus.serial_strobe = 1'b0;
  endtask

  task automatic set_entry(input int i, input int sw12, input int dw);
    logic [31:0] d;
    d = {i[3:0], sw12[11:0], dw[15:0]};
    wr(BASE + 7'd1, d);
    if (i < NE) begin
      m_sw[i] = sw12 % 64;
      m_dw[i] = dw;
    end
  endtask

  task automatic set_settle(input int s);
    wr(BASE + 7'd2, 32'(s));
    m_settle = s;
  endtask

  task automatic ctrl(input bit start, input bit cont, input bit abort, input int last);
    logic [31:0] d;
    d       = '0;
    d[0]    = start;
    d[1]    = cont;
    d[2]    = abort;
    d[11:8] = last[3:0];
    m_last  = (last >= NE) ? NE - 1 : last;
    wr(BASE, d);
  endtask

  task automatic expect_pass(input bit from_start);
    for (int i = 0; i <= m_last; i++) begin
      exp_q.push_back('{EV_START, m_sw[i], i, (i == 0 && from_start) ? m_settle + 1 : m_settle + 2});
      exp_q.push_back('{EV_END, m_dw[i] + 1, 0, 0});
    end
    exp_q.push_back('{EV_DONE, m_last, 0, 0});
  endtask

  function automatic int pass_cycles();
    int n = 0;
    for (int i = 0; i <= m_last; i++) n += m_settle + m_dw[i] + 3;
    return n;
  endfunction

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 3000) begin
      @(negedge clock);
      cycles++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  // One non-continuous sweep from IDLE, also checking total busy time.
  task automatic run_sweep(input int last);
    int cyc;
    ctrl(1'b1, 1'b0, 1'b0, last);
    expect_pass(1'b1);
    wait_idle(cyc);
    check("sweep_busy_cycles", cyc, pass_cycles());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int c;
    sbus.serial_strobe = 1'b0;
    sbus.serial_addr   = '0;
    sbus.serial_data   = '0;
    for (int i = 0; i < NE; i++) begin
      m_sw[i] = 0;
      m_dw[i] = 0;
    end
    m_settle = 0;
    m_last   = 0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_sw_out", int'(sw_out), 0);
    check("rst_capture_en", int'(capture_en), 0);
    check("rst_cur_idx", int'(cur_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sweep_done", int'(sweep_done), 0);

    // Basic three-entry sweep
    set_entry(0, 1, 4);
    set_entry(1, 2, 4);
    set_entry(2, 3, 4);
    set_settle(2);
    check("idle_live_sw", int'(sw_out), 1);
    run_sweep(2);
    check("post_sweep_idx", int'(cur_idx), 0);

    // Continuous two-entry sweep, cleared after the first pass
    set_entry(0, 1, 3);
    set_entry(1, 2, 3);
    set_settle(1);
    ctrl(1'b1, 1'b1, 1'b0, 1);
    expect_pass(1'b1);
    expect_pass(1'b0);
    c = 0;
    while (!sweep_done && c < 1000) begin
      @(negedge clock);
      c++;
    end
    check("cont_first_done", int'(sweep_done), 1);
    ctrl(1'b0, 1'b0, 1'b0, 1);
    wait_idle(cyc);

    // Abort in the dwell of entry 1
    set_entry(0, 5, 2);
    set_entry(1, 6, 20);
    set_entry(2, 7, 2);
    ctrl(1'b1, 1'b0, 1'b0, 2);
    exp_q.push_back('{EV_START, 5, 0, m_settle + 1});
    exp_q.push_back('{EV_END, 3, 0, 0});
    exp_q.push_back('{EV_START, 6, 1, m_settle + 2});
    exp_q.push_back('{EV_END, 1, 0, 0});
    c = 0;
    while (!(capture_en && cur_idx == 4'd1) && c < 1000) begin
      @(negedge clock);
      c++;
    end
    check("abort_reached_dwell1", int'(capture_en), 1);
    ctrl(1'b0, 1'b0, 1'b1, 2);
    check("abort_busy", int'(busy), 0);
    check("abort_capture_en", int'(capture_en), 0);
    check("abort_cur_idx", int'(cur_idx), 0);
    check("abort_sweep_done", int'(sweep_done), 0);

    // Start and abort together stay idle
    ctrl(1'b1, 1'b0, 1'b1, 2);
    check("start_abort_busy", int'(busy), 0);
    repeat (4) @(negedge clock);
    check("start_abort_busy_later", int'(busy), 0);

    // Zero settle and zero dwell: three cycles per entry
    for (int i = 0; i < 4; i++) set_entry(i, 10 + i, 0);
    set_settle(0);
    run_sweep(3);

    // Out-of-range table writes ignored; last=12 clamps to 7
    for (int i = 0; i < NE; i++) set_entry(i, 20 + i, i % 3);
    set_entry(8, 63, 9);
    set_entry(15, 62, 9);
    check("oob_write_entry0", int'(sw_out), m_sw[0]);
    set_settle(1);
    run_sweep(12);

    // Randomised sweeps
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NE; i++) set_entry(i, int'($urandom_range(0, 4095)), int'($urandom_range(0, 5)));
      set_settle(int'($urandom_range(0, 3)));
      check("rand_idle_sw", int'(sw_out), m_sw[0]);
      run_sweep(int'($urandom_range(0, NE - 1)));
    end

`ifdef RFE_SWEEP_HOLD_EN
    // Hold in SETTLE is ignored; ten held dwell cycles stretch capture
    set_entry(0, 11, 5);
    set_settle(3);
    ctrl(1'b1, 1'b0, 1'b0, 0);
    hold = 1'b1;
    exp_q.push_back('{EV_START, 11, 0, 4});
    exp_q.push_back('{EV_END, 5 + 1 + 10, 0, 0});
    exp_q.push_back('{EV_DONE, 0, 0, 0});
    c = 0;
    while (!capture_en && c < 1000) begin
      @(negedge clock);
      c++;
    end
    check("hold_reached_dwell", int'(capture_en), 1);
    repeat (10) @(negedge clock);
    hold = 1'b0;
    wait_idle(cyc);
`endif

    // Reset mid-sweep clears the table and settle
    set_entry(0, 42, 3);
    set_settle(10);
    ctrl(1'b1, 1'b0, 1'b0, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NE; i++) begin
      m_sw[i] = 0;
      m_dw[i] = 0;
    end
    m_settle = 0;
    m_last   = 0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_sw_out", int'(sw_out), 0);
    check("midrst_cur_idx", int'(cur_idx), 0);
    run_sweep(0);

    repeat (5) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
